// File: rtl/reglk_boot_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// reglk_seq_pkg
// Shared types and helpers for the register-lock boot sequencer.
//   state_e      : sequencer FSM states
//   W_BYTE/HALF/WORD : access width encodings on mem_width / tbl_width
//   width_mask() : significant-bit mask for a given access width
// ----------------------------------------------------------------------------
package reglk_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_WRITE    = 4'd2,
        ST_RD_ADDR  = 4'd3,
        ST_RD_CHK   = 4'd4,
        ST_LOCK_WR  = 4'd5,
        ST_LOCK_RD  = 4'd6,
        ST_LOCK_CHK = 4'd7,
        ST_DONE     = 4'd8,
        ST_ERROR    = 4'd9
    } state_e;

    localparam logic [2:0] W_BYTE = 3'd0;
    localparam logic [2:0] W_HALF = 3'd1;
    localparam logic [2:0] W_WORD = 3'd2;

    // Illegal widths never reach the compare (FETCH aborts on them), so the
    // default simply compares the full word.
    function automatic logic [31:0] width_mask(input logic [2:0] w);
        logic [31:0] m;
        case (w)
            W_BYTE:  m = 32'h0000_00FF;
            W_HALF:  m = 32'h0000_FFFF;
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/reglk_boot_sequencer_if.sv
// ----------------------------------------------------------------------------
// reglk_bus_if
// Write/read bus between the boot sequencer (master) and the register-lock
// block (slave).
//   write_enable : one-cycle write strobe
//   mem_width    : access width (0=byte, 1=half, 2=word)
//   addr         : access address
//   write_data   : write data
//   read_data    : read data, valid the cycle after addr is presented with
//                  write_enable low
// ----------------------------------------------------------------------------
interface reglk_bus_if;
    logic        write_enable;
    logic [2:0]  mem_width;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;

    modport master (
        output write_enable,
        output mem_width,
        output addr,
        output write_data,
        input  read_data
    );

    modport slave (
        input  write_enable,
        input  mem_width,
        input  addr,
        input  write_data,
        output read_data
    );
endinterface

// File: rtl/reglk_boot_sequencer_rb_checker.sv
// ----------------------------------------------------------------------------
// reglk_rb_checker
// Combinational readback compare: only the bits covered by the access width
// take part in the comparison.
//   rd_data_i : data returned by the register-lock block
//   wr_data_i : data that was written
//   width_i   : access width encoding
//   match_o   : 1 when the masked values agree
// ----------------------------------------------------------------------------
module reglk_rb_checker
    import reglk_seq_pkg::*;
(
    input  logic [31:0] rd_data_i,
    input  logic [31:0] wr_data_i,
    input  logic [2:0]  width_i,
    output logic        match_o
);
    logic [31:0] mask;

    assign mask    = width_mask(width_i);
    assign match_o = ((rd_data_i ^ wr_data_i) & mask) == 32'h0;
endmodule

// File: rtl/reglk_boot_sequencer.sv
// ----------------------------------------------------------------------------
// reglk_boot_sequencer
// Walks an external programming table, writing each entry to the
// register-lock block and reading it back, then writes and verifies the lock
// register. Restarts from entry 0 on every power-state wake so lock bits are
// always re-applied.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : pulse, begin sequence when not busy
//   pwr_wake          : pulse, unconditional restart (wins over start)
//   tbl_idx           : requested table entry
//   tbl_addr/data/width : table entry contents (combinational from tbl_idx)
//   bus               : register-lock bus (master side)
//   busy/done/locked/error : sequence status
//   err_idx           : failing entry, NUM_ENTRIES denotes the lock step
// ----------------------------------------------------------------------------
module reglk_boot_sequencer
    import reglk_seq_pkg::*;
#(
    parameter int          NUM_ENTRIES = 8,
    parameter int          IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1,
    parameter logic [31:0] LOCK_ADDR   = 32'h0000_0000,
    parameter logic [31:0] LOCK_VALUE  = 32'hFFFF_FFFF,
    parameter int          MAX_RETRY   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               pwr_wake,
    output logic [IDX_W-1:0]   tbl_idx,
    input  logic [31:0]        tbl_addr,
    input  logic [31:0]        tbl_data,
    input  logic [2:0]         tbl_width,
    reglk_bus_if.master        bus,
    output logic               busy,
    output logic               done,
    output logic               locked,
    output logic               error,
    output logic [IDX_W:0]     err_idx
);
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [IDX_W:0]       err_idx_q, err_idx_d;
    logic [31:0]          entry_addr_q, entry_addr_d;
    logic [31:0]          entry_data_q, entry_data_d;
    logic [2:0]           entry_width_q, entry_width_d;
    logic [31:0]          bus_addr_q, bus_addr_d;
    logic [31:0]          bus_data_q, bus_data_d;
    logic [2:0]           bus_width_q, bus_width_d;

    logic                 rb_match;
    logic                 last_entry;
    logic                 can_retry;

    // The bus registers always hold the data of the access in flight, so the
    // checker compares against them in both the entry and the lock step.
    reglk_rb_checker u_rb_checker (
        .rd_data_i (bus.read_data),
        .wr_data_i (bus_data_q),
        .width_i   (bus_width_q),
        .match_o   (rb_match)
    );

    assign last_entry = (idx_q == IDX_W'(NUM_ENTRIES - 1));
    assign can_retry  = (retry_q < RETRY_W'(MAX_RETRY));

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            retry_q       <= '0;
            err_idx_q     <= '0;
            entry_addr_q  <= '0;
            entry_data_q  <= '0;
            entry_width_q <= '0;
            bus_addr_q    <= '0;
            bus_data_q    <= '0;
            bus_width_q   <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            retry_q       <= retry_d;
            err_idx_q     <= err_idx_d;
            entry_addr_q  <= entry_addr_d;
            entry_data_q  <= entry_data_d;
            entry_width_q <= entry_width_d;
            bus_addr_q    <= bus_addr_d;
            bus_data_q    <= bus_data_d;
            bus_width_q   <= bus_width_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        retry_d       = retry_q;
        err_idx_d     = err_idx_q;
        entry_addr_d  = entry_addr_q;
        entry_data_d  = entry_data_q;
        entry_width_d = entry_width_q;

        if (pwr_wake) begin
            // Wake overrides everything, including a write strobe in this
            // cycle: the next cycle is FETCH, never a repeated WRITE.
            state_d   = ST_FETCH;
            idx_d     = '0;
            retry_d   = '0;
            err_idx_d = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state_d   = ST_FETCH;
                        idx_d     = '0;
                        retry_d   = '0;
                        err_idx_d = '0;
                    end
                end
                ST_FETCH: begin
                    entry_addr_d  = tbl_addr;
                    entry_data_d  = tbl_data;
                    entry_width_d = tbl_width;
                    if (tbl_width > W_WORD) begin
                        state_d   = ST_ERROR;
                        err_idx_d = {1'b0, idx_q};
                    end else begin
                        state_d = ST_WRITE;
                    end
                end
                ST_WRITE:   state_d = ST_RD_ADDR;
                ST_RD_ADDR: state_d = ST_RD_CHK;
                ST_RD_CHK: begin
                    if (rb_match) begin
                        retry_d = '0;
                        if (last_entry) begin
                            state_d = ST_LOCK_WR;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = ST_FETCH;
                        end
                    end else if (can_retry) begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = ST_WRITE;
                    end else begin
                        state_d   = ST_ERROR;
                        err_idx_d = {1'b0, idx_q};
                    end
                end
                ST_LOCK_WR: state_d = ST_LOCK_RD;
                ST_LOCK_RD: state_d = ST_LOCK_CHK;
                ST_LOCK_CHK: begin
                    if (rb_match) begin
                        retry_d = '0;
                        state_d = ST_DONE;
                    end else if (can_retry) begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = ST_LOCK_WR;
                    end else begin
                        state_d   = ST_ERROR;
                        err_idx_d = (IDX_W + 1)'(NUM_ENTRIES);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Bus registers load on entry to a write state and hold otherwise, so
    // addr/width stay stable through the readback cycle and beyond.
    always_comb begin
        bus_addr_d  = bus_addr_q;
        bus_data_d  = bus_data_q;
        bus_width_d = bus_width_q;
        if (state_d == ST_WRITE) begin
            bus_addr_d  = entry_addr_d;
            bus_data_d  = entry_data_d;
            bus_width_d = entry_width_d;
        end else if (state_d == ST_LOCK_WR) begin
            bus_addr_d  = LOCK_ADDR;
            bus_data_d  = LOCK_VALUE;
            bus_width_d = W_WORD;
        end
    end

    // ---------------- outputs ----------------
    // Decoded from the asynchronously reset state, so reset removes the write
    // strobe immediately.
    always_comb begin
        bus.write_enable = 1'b0;
        busy             = 1'b0;
        done             = 1'b0;
        locked           = 1'b0;
        error            = 1'b0;
        case (state_q)
            ST_IDLE:  ;
            ST_DONE: begin
                done   = 1'b1;
                locked = 1'b1;
            end
            ST_ERROR: error = 1'b1;
            ST_WRITE, ST_LOCK_WR: begin
                bus.write_enable = 1'b1;
                busy             = 1'b1;
            end
            default: busy = 1'b1;
        endcase
    end

    assign bus.addr       = bus_addr_q;
    assign bus.write_data = bus_data_q;
    assign bus.mem_width  = bus_width_q;
    assign tbl_idx        = idx_q;
    assign err_idx        = err_idx_q;

endmodule

// File: tb/tb_reglk_boot_sequencer.sv
module tb_reglk_boot_sequencer;
    localparam int N     = 2;
    localparam int IW    = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          pwr_wake = 1'b0;
    logic [IW-1:0] tbl_idx;
    logic [31:0]   tbl_addr, tbl_data;
    logic [2:0]    tbl_width;
    logic          busy, done, locked, error;
    logic [IW:0]   err_idx;

    logic [31:0]   t_addr  [0:N-1];
    logic [31:0]   t_data  [0:N-1];
    logic [2:0]    t_width [0:N-1];

    int            n_cmp = 0;
    int            n_mis = 0;
    int            resp_mode = 0;
    int            wr_total = 0;
    int            viol = 0;
    int            base;
    logic          prev_we = 1'b0;
    logic [31:0]   last_wr = '0;
    logic [31:0]   wr_addr_log [0:255];
    logic [31:0]   wr_data_log [0:255];
    logic [2:0]    wr_wid_log  [0:255];

    reglk_bus_if bus_if ();

    reglk_boot_sequencer #(
        .NUM_ENTRIES (N),
        .IDX_W       (IW),
        .LOCK_ADDR   (32'h0000_0000),
        .LOCK_VALUE  (32'hFFFF_FFFF),
        .MAX_RETRY   (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pwr_wake  (pwr_wake),
        .tbl_idx   (tbl_idx),
        .tbl_addr  (tbl_addr),
        .tbl_data  (tbl_data),
        .tbl_width (tbl_width),
        .bus       (bus_if),
        .busy      (busy),
        .done      (done),
        .locked    (locked),
        .error     (error),
        .err_idx   (err_idx)
    );

    always #5 clk = ~clk;

    assign tbl_addr  = t_addr[tbl_idx];
    assign tbl_data  = t_data[tbl_idx];
    assign tbl_width = t_width[tbl_idx];

    // Responder: mode 0 echoes the last write, mode 1 sets the upper half,
    // mode 2 returns zero for address 0x14.
    initial bus_if.read_data = '0;
    always @(posedge clk) begin
        if (bus_if.write_enable) begin
            last_wr <= bus_if.write_data;
        end else begin
            case (resp_mode)
                1:       bus_if.read_data <= last_wr | 32'hFFFF_0000;
                2:       bus_if.read_data <= (bus_if.addr == 32'h14) ? 32'h0 : last_wr;
                default: bus_if.read_data <= last_wr;
            endcase
        end
    end

    // Write log and bus rule monitor.
    always @(posedge clk) begin
        prev_we <= bus_if.write_enable;
        if (bus_if.write_enable) begin
            wr_addr_log[wr_total[7:0]] <= bus_if.addr;
            wr_data_log[wr_total[7:0]] <= bus_if.write_data;
            wr_wid_log[wr_total[7:0]]  <= bus_if.mem_width;
            wr_total <= wr_total + 1;
            if (prev_we || !busy) viol <= viol + 1;
        end
    end

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic pulse_wake();
        pwr_wake = 1'b1;
        tick(1);
        pwr_wake = 1'b0;
    endtask

    task automatic load_default_table();
        t_addr[0] = 32'h10; t_data[0] = 32'hA5;        t_width[0] = 3'd0;
        t_addr[1] = 32'h14; t_data[1] = 32'h1234_5678; t_width[1] = 3'd2;
    endtask

    initial begin
        load_default_table();

        // ---- reset state ----
        tick(3);
        chk_val("rst_busy",   32'(busy), 0);
        chk_val("rst_done",   32'(done), 0);
        chk_val("rst_locked", 32'(locked), 0);
        chk_val("rst_error",  32'(error), 0);
        chk_val("rst_erridx", 32'(err_idx), 0);
        chk_val("rst_we",     32'(bus_if.write_enable), 0);
        chk_val("rst_addr",   bus_if.addr, 0);
        rst_n = 1'b1;
        tick(2);
        $display("reset: busy=%0d done=%0d locked=%0d", busy, done, locked);

        // ---- nominal sequence, echo responder ----
        base = wr_total;
        pulse_start();
        chk_val("t1_busy", 32'(busy), 1);
        tick(10);
        chk_val("t1_done_c11", 32'(done), 0);
        tick(1);
        chk_val("t1_done",   32'(done), 1);
        chk_val("t1_locked", 32'(locked), 1);
        chk_val("t1_busy0",  32'(busy), 0);
        chk_val("t1_erridx", 32'(err_idx), 0);
        chk_val("t1_nwr",    32'(wr_total - base), 3);
        chk_val("t1_a0", wr_addr_log[base[7:0]], 32'h10);
        chk_val("t1_d0", wr_data_log[base[7:0]], 32'hA5);
        chk_val("t1_w0", 32'(wr_wid_log[base[7:0]]), 0);
        chk_val("t1_a1", wr_addr_log[8'(base + 1)], 32'h14);
        chk_val("t1_d1", wr_data_log[8'(base + 1)], 32'h1234_5678);
        chk_val("t1_a2", wr_addr_log[8'(base + 2)], 32'h0);
        chk_val("t1_d2", wr_data_log[8'(base + 2)], 32'hFFFF_FFFF);
        chk_val("t1_w2", 32'(wr_wid_log[8'(base + 2)]), 2);
        $display("nominal: writes=%0d done=%0d locked=%0d", wr_total - base, done, locked);

        // ---- half-width entry, upper bits differ on readback ----
        t_addr[0] = 32'h20; t_data[0] = 32'h0000_BEEF; t_width[0] = 3'd1;
        t_addr[1] = 32'h24; t_data[1] = 32'h11;        t_width[1] = 3'd0;
        resp_mode = 1;
        base = wr_total;
        pulse_start();
        tick(11);
        chk_val("t2_done",  32'(done), 1);
        chk_val("t2_nwr",   32'(wr_total - base), 3);
        chk_val("t2_a0",    wr_addr_log[base[7:0]], 32'h20);
        chk_val("t2_w0",    32'(wr_wid_log[base[7:0]]), 1);
        $display("half-width: writes=%0d done=%0d", wr_total - base, done);

        // ---- entry 1 never reads back: retries then error ----
        load_default_table();
        resp_mode = 2;
        base = wr_total;
        pulse_start();
        tick(13);
        chk_val("t3_err_c14", 32'(error), 0);
        tick(1);
        chk_val("t3_error",  32'(error), 1);
        chk_val("t3_erridx", 32'(err_idx), 1);
        chk_val("t3_locked", 32'(locked), 0);
        chk_val("t3_busy",   32'(busy), 0);
        chk_val("t3_done",   32'(done), 0);
        chk_val("t3_nwr",    32'(wr_total - base), 4);
        chk_val("t3_a3",     wr_addr_log[8'(base + 3)], 32'h14);
        $display("retry-exhaust: writes=%0d error=%0d err_idx=%0d", wr_total - base, error, err_idx);

        // ---- illegal width at entry 0 ----
        resp_mode = 0;
        t_width[0] = 3'd5;
        base = wr_total;
        pulse_start();
        chk_val("t4_busy",  32'(busy), 1);
        chk_val("t4_err_f", 32'(error), 0);
        tick(1);
        chk_val("t4_error",  32'(error), 1);
        chk_val("t4_erridx", 32'(err_idx), 0);
        tick(3);
        chk_val("t4_nwr",    32'(wr_total - base), 0);
        $display("illegal-width: error=%0d err_idx=%0d writes=%0d", error, err_idx, wr_total - base);

        // ---- completed, then power wake re-locks ----
        load_default_table();
        pulse_start();
        tick(11);
        chk_val("t5_locked", 32'(locked), 1);
        base = wr_total;
        pulse_wake();
        chk_val("t5_unlock", 32'(locked), 0);
        chk_val("t5_busy",   32'(busy), 1);
        chk_val("t5_done0",  32'(done), 0);
        tick(10);
        chk_val("t5_lock_c11", 32'(locked), 0);
        tick(1);
        chk_val("t5_relock", 32'(locked), 1);
        chk_val("t5_nwr",    32'(wr_total - base), 3);
        chk_val("t5_a2",     wr_addr_log[8'(base + 2)], 32'h0);
        $display("wake-relock: writes=%0d locked=%0d", wr_total - base, locked);

        // ---- wake during RD_CHK of entry 1, start ignored mid-sequence ----
        base = wr_total;
        pulse_start();          // now cycle 1
        tick(2);                // cycle 3
        pulse_start();          // ignored; now cycle 4
        tick(4);                // cycle 8 = RD_CHK of entry 1
        chk_val("t6_idx1", 32'(tbl_idx), 1);
        pulse_wake();           // cycle 9
        chk_val("t6_idx0", 32'(tbl_idx), 0);
        chk_val("t6_busy", 32'(busy), 1);
        tick(10);
        chk_val("t6_done_c19", 32'(done), 0);
        tick(1);
        chk_val("t6_done", 32'(done), 1);
        chk_val("t6_nwr",  32'(wr_total - base), 5);
        $display("wake-mid: writes=%0d done=%0d", wr_total - base, done);

        // ---- reset asserted mid-WRITE ----
        pulse_start();          // cycle 1 FETCH
        tick(1);                // cycle 2 WRITE
        chk_val("t7_we",   32'(bus_if.write_enable), 1);
        chk_val("t7_addr", bus_if.addr, 32'h10);
        #2 rst_n = 1'b0;
        #1;
        chk_val("t7_we0",   32'(bus_if.write_enable), 0);
        chk_val("t7_busy0", 32'(busy), 0);
        chk_val("t7_addr0", bus_if.addr, 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        chk_val("t7_idle", 32'(busy), 0);
        $display("reset-mid-write: we=%0d busy=%0d", bus_if.write_enable, busy);

        chk_val("bus_rules", 32'(viol), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end
endmodule
